// File: rtl/proc_bist_driver_if.sv
// Processor-side stimulus/response bus between the BIST driver and the datapath.
// The master modport is the driver; the slave modport is the processor under test.
interface proc_bist_driver_if #(
    parameter int unsigned OP_W   = 4,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned RESP_W = 8
);
    logic [OP_W-1:0]   drv_op;
    logic [DATA_W-1:0] drv_data;
    logic [RESP_W-1:0] dut_resp;

    modport master (output drv_op, output drv_data, input dut_resp);
    modport slave  (input drv_op, input drv_data, output dut_resp);
endinterface

// File: rtl/proc_bist_driver.sv
// Vector sweep driver plus MISR response compactor for the processor datapath.
// Define PROC_BIST_FULL_SWEEP_EN for the full op x data cross-product sweep.
module proc_bist_driver #(
    parameter int unsigned       OP_W      = 4,
    parameter int unsigned       DATA_W    = 4,
    parameter int unsigned       RESP_W    = 8,
    parameter int unsigned       SETTLE    = 1,
    parameter logic [RESP_W-1:0] MISR_POLY = 8'h1D,
    parameter logic [RESP_W-1:0] MISR_SEED = 8'h00,
    parameter logic [RESP_W-1:0] GOLDEN    = 8'h00
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    proc_bist_driver_if.master  bus,
    output logic [7:0]          vec_idx,
    output logic                busy,
    output logic                done,
    output logic [RESP_W-1:0]   signature,
    output logic                pass
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

`ifdef PROC_BIST_FULL_SWEEP_EN
    localparam int unsigned NUM_VEC = 1 << (OP_W + DATA_W);
`else
    localparam int unsigned NUM_VEC = (1 << DATA_W) + (1 << OP_W);
`endif
    localparam logic [7:0] LAST_IDX  = 8'(NUM_VEC - 1);
    localparam logic [7:0] A_LEN     = 8'(1 << DATA_W);
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic [RESP_W-1:0] misr_nxt;

    function automatic logic [OP_W+DATA_W-1:0] vec_of(input logic [7:0] idx);
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] data;
`ifdef PROC_BIST_FULL_SWEEP_EN
        op   = OP_W'(idx >> DATA_W);
        data = DATA_W'(idx);
`else
        // Phase A walks the operand with op=0, phase B walks the opcode with data=0.
        op   = '0;
        data = '0;
        if (idx < A_LEN)
            data = DATA_W'(idx);
        else
            op = OP_W'(idx - A_LEN);
`endif
        return {op, data};
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start && !abort) state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (abort)
                    state_nxt = S_IDLE;
                else if (cnt == 4'd1)
                    state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort)
                    state_nxt = S_IDLE;
                else if (vec_idx == LAST_IDX)
                    state_nxt = S_DONE;
                else
                    state_nxt = S_SETTLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_SETTLE) || (state == S_SAMPLE);
        done = (state == S_DONE);
        pass = done && (signature == GOLDEN);
    end

    always_comb begin
        misr_nxt = {signature[RESP_W-2:0], 1'b0}
                 ^ (signature[RESP_W-1] ? MISR_POLY : '0)
                 ^ bus.dut_resp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            vec_idx      <= '0;
            bus.drv_op   <= '0;
            bus.drv_data <= '0;
            signature    <= MISR_SEED;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start && !abort) begin
                        {bus.drv_op, bus.drv_data} <= vec_of(8'd0);
                        vec_idx   <= '0;
                        signature <= MISR_SEED;
                        cnt       <= SETTLE_LD;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        bus.drv_op   <= '0;
                        bus.drv_data <= '0;
                        vec_idx      <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    // An abort landing on the sample cycle drops that response.
                    if (abort) begin
                        bus.drv_op   <= '0;
                        bus.drv_data <= '0;
                        vec_idx      <= '0;
                    end else begin
                        signature <= misr_nxt;
                        if (vec_idx != LAST_IDX) begin
                            vec_idx <= vec_idx + 8'd1;
                            {bus.drv_op, bus.drv_data} <= vec_of(vec_idx + 8'd1);
                            cnt <= SETTLE_LD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_bist_driver.sv
// Directed bench for proc_bist_driver: sweep order, timing, abort, restart and reset.
module tb_proc_bist_driver;

`ifdef PROC_BIST_FULL_SWEEP_EN
    localparam int NUM_VEC = 256;
`else
    localparam int NUM_VEC = 32;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] vec_idx;
    logic       busy;
    logic       done;
    logic [7:0] signature;
    logic       pass;

    int checks = 0;
    int errors = 0;

    proc_bist_driver_if #(.OP_W(4), .DATA_W(4), .RESP_W(8)) bus ();

    proc_bist_driver #(
        .OP_W(4), .DATA_W(4), .RESP_W(8), .SETTLE(1),
        .MISR_POLY(8'h1D), .MISR_SEED(8'h00), .GOLDEN(8'h00)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(bus),
        .vec_idx(vec_idx), .busy(busy), .done(done),
        .signature(signature), .pass(pass)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] r);
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ r;
    endfunction

    function automatic logic [7:0] misr_run(input int n, input logic [7:0] r);
        logic [7:0] s = 8'h00;
        for (int k = 0; k < n; k++) s = misr_step(s, r);
        return s;
    endfunction

    // Expected {op,data} for vector i, packed as op in [7:4], data in [3:0].
    function automatic logic [7:0] exp_vec(input int i);
`ifdef PROC_BIST_FULL_SWEEP_EN
        return 8'(i);
`else
        if (i < 16) return {4'd0, 4'(i)};
        return {4'(i - 16), 4'd0};
`endif
    endfunction

    initial begin
        logic [7:0] ev;
        logic [7:0] model;

        rst = 1'b1; start = 1'b0; abort = 1'b0; bus.dut_resp = 8'h00;
        tick; tick;
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sig", signature, 8'h00);
        check("rst_op", bus.drv_op, 0);
        check("rst_data", bus.drv_data, 0);
        check("rst_idx", vec_idx, 0);
        check("rst_pass", pass, 0);

        // Full sweep with zero response; monitor each sample cycle.
        start = 1'b1; tick; start = 1'b0;
        check("acc_busy", busy, 1);
        check("acc_idx", vec_idx, 0);
        for (int i = 0; i < NUM_VEC; i++) begin
            tick;
            ev = exp_vec(i);
            check("seq_op", bus.drv_op, ev[7:4]);
            check("seq_data", bus.drv_data, ev[3:0]);
            check("seq_idx", vec_idx, i);
            check("seq_busy", busy, 1);
            check("seq_done", done, 0);
            check("seq_pass", pass, 0);
            tick;
        end
        ev = exp_vec(NUM_VEC - 1);
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_sig", signature, 8'h00);
        check("end_pass", pass, 1);
        check("end_op", bus.drv_op, ev[7:4]);
        check("end_data", bus.drv_data, ev[3:0]);
        check("end_idx", vec_idx, NUM_VEC - 1);

        // Abort after the third sample with constant response 1.
        bus.dut_resp = 8'h01;
        start = 1'b1; tick; start = 1'b0;
        check("ab_clr_done", done, 0);
        repeat (6) tick;
        check("ab_pre_data", bus.drv_data, 3);
        abort = 1'b1; tick; abort = 1'b0;
        check("ab_sig", signature, 8'h07);
        check("ab_busy", busy, 0);
        check("ab_done", done, 0);
        check("ab_op", bus.drv_op, 0);
        check("ab_data", bus.drv_data, 0);
        check("ab_pass", pass, 0);

        // Abort beats start in the same cycle.
        start = 1'b1; abort = 1'b1; tick; abort = 1'b0;
        check("abst_busy", busy, 0);
        tick; start = 1'b0;
        check("abst_acc", busy, 1);

        // Start while busy is ignored.
        repeat (21) tick;
        check("ign_idx_pre", vec_idx, 10);
        start = 1'b1; tick; start = 1'b0;
        check("ign_idx", vec_idx, 11);
        check("ign_busy", busy, 1);
        repeat (2 * NUM_VEC - 22) tick;
        model = misr_run(NUM_VEC, 8'h01);
        check("r1_done", done, 1);
        check("r1_sig", signature, model);
        check("r1_pass", pass, (model == 8'h00));

        // Held start: reload seed, complete, then restart immediately from DONE.
        bus.dut_resp = 8'h00;
        start = 1'b1; tick;
        check("hs_sig", signature, 8'h00);
        check("hs_busy", busy, 1);
        check("hs_done", done, 0);
        repeat (2 * NUM_VEC) tick;
        check("hs_end_done", done, 1);
        check("hs_end_pass", pass, 1);
        tick;
        check("hs_restart_busy", busy, 1);
        check("hs_restart_done", done, 0);
        start = 1'b0;

        // Reset mid-sweep at vector 10.
        bus.dut_resp = 8'h5A;
        repeat (20) tick;
        check("mr_idx", vec_idx, 10);
        check("mr_data", bus.drv_data, 10);
        check("mr_sig", signature, misr_run(10, 8'h5A));
        rst = 1'b1; tick; rst = 1'b0;
        check("mr_rsig", signature, 8'h00);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        check("mr_op", bus.drv_op, 0);
        check("mr_rdata", bus.drv_data, 0);
        check("mr_ridx", vec_idx, 0);
        repeat (4) tick;
        check("mr_noresume", busy, 0);
        check("mr_idx_hold", vec_idx, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
